// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host interface.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StFinish
  } ps2_tx_state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'b00,
    ErrTimeout = 2'b01,
    ErrNack    = 2'b10
  } ps2_err_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronises one PS/2 pad, rejects glitches shorter than FILTER_LEN samples
// and flags filtered 1->0 transitions with a one-cycle strobe.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      r_sync;
  logic            r_level;
  logic            r_fall;
  logic [CntW-1:0] r_cnt;
  logic            w_flip;

  // Flip on the FILTER_LEN-th consecutive sample that disagrees with the level.
  assign w_flip = (r_sync[1] != r_level) && (r_cnt == CntW'(FILTER_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pad};
      r_fall <= w_flip & r_level;
      if ((r_sync[1] == r_level) || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_level <= r_sync[1];
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift a
// byte with odd parity and stop on device clocks, then check the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned SETUP_CYCLES   = 250,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       iCLK_50,
  input  logic       Reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_cause
);

  localparam int unsigned CntMax = max3(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  ps2_tx_state_e   r_state, w_state_nxt;
  ps2_err_e        r_err, w_err_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_parity, w_parity_nxt;
  logic            r_dat_oe, w_dat_oe_nxt;
  logic            r_clk_oe, r_busy, r_done, r_error;
  logic            w_clk_level, w_clk_fall, w_dat_level, w_dat_fall_unused;
  logic            w_bit_val, w_timeout;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .i_clk  (iCLK_50),
    .i_rst  (Reset),
    .i_pad  (ps2_clk_in),
    .o_level(w_clk_level),
    .o_fall (w_clk_fall)
  );

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_dat_filter (
    .i_clk  (iCLK_50),
    .i_rst  (Reset),
    .i_pad  (ps2_dat_in),
    .o_level(w_dat_level),
    .o_fall (w_dat_fall_unused)
  );

  assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Frame bit k: 0..7 data LSB first, 8 parity, 9 stop.
  always_comb begin
    if (r_bit < 4'd8) begin
      w_bit_val = r_data[r_bit[2:0]];
    end else if (r_bit == 4'd8) begin
      w_bit_val = r_parity;
    end else begin
      w_bit_val = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_data_nxt   = r_data;
    w_parity_nxt = r_parity;
    w_dat_oe_nxt = r_dat_oe;
    unique case (r_state)
      StIdle: begin
        if (tx_start) begin
          w_data_nxt   = tx_data;
          w_parity_nxt = ~^tx_data;
          w_err_nxt    = ErrNone;
          w_bit_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = StInhibit;
        end
      end
      StInhibit: begin
        if (r_cnt == CntW'(INHIBIT_CYCLES - 1)) begin
          w_cnt_nxt    = '0;
          w_dat_oe_nxt = 1'b1;
          w_state_nxt  = StReq;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StReq: begin
        if (r_cnt == CntW'(SETUP_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StShift;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StShift, StAck, StWaitIdle: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_timeout) begin
          w_dat_oe_nxt = 1'b0;
          w_err_nxt    = ErrTimeout;
          w_state_nxt  = StFinish;
        end else if (r_state == StShift) begin
          if (w_clk_fall) begin
            w_dat_oe_nxt = ~w_bit_val;
            w_bit_nxt    = r_bit + 4'd1;
            if (r_bit == 4'd9) begin
              w_state_nxt = StAck;
            end
          end
        end else if (r_state == StAck) begin
          if (w_clk_fall) begin
            if (w_dat_level) begin
              w_err_nxt = ErrNack;
            end
            w_state_nxt = StWaitIdle;
          end
        end else if (w_clk_level && w_dat_level) begin
          w_state_nxt = StFinish;
        end
      end
      StFinish: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Pad and status outputs are registered from the next state so they never glitch.
  always_ff @(posedge iCLK_50) begin
    if (Reset) begin
      r_state  <= StIdle;
      r_err    <= ErrNone;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_dat_oe <= 1'b0;
      r_clk_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_data   <= w_data_nxt;
      r_parity <= w_parity_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_clk_oe <= (w_state_nxt == StInhibit) || (w_state_nxt == StReq);
      r_busy   <= (w_state_nxt != StIdle) && (w_state_nxt != StFinish);
      r_done   <= (w_state_nxt == StFinish) && (w_err_nxt == ErrNone);
      r_error  <= (w_state_nxt == StFinish) && (w_err_nxt != ErrNone);
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_error   = r_error;
  assign err_cause  = r_err;

endmodule
